// File: rtl/net_send_frame_tx.sv
// rtl/net_send_frame_tx.sv - prepends a protocol header to a payload stream and emits one frame toward the MAC
// Optional build macro: NET_SEND_MIN_FRAME_PAD_EN (zero-pads frames shorter than 60 bytes).
module net_send_frame_tx #(
    parameter int HDR_BYTES = 54,
    parameter int DATA_W    = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [HDR_BYTES*8-1:0] hdr_tdata,
    input  logic                   hdr_tuser,
    input  logic                   hdr_tvalid,
    output logic                   hdr_tready,
    input  logic [DATA_W-1:0]      pay_tdata,
    input  logic [DATA_W/8-1:0]    pay_tkeep,
    input  logic                   pay_tlast,
    input  logic                   pay_tvalid,
    output logic                   pay_tready,
    output logic [DATA_W-1:0]      NET_TX_tdata,
    output logic [DATA_W/8-1:0]    NET_TX_tkeep,
    output logic                   NET_TX_tlast,
    output logic                   NET_TX_tvalid,
    input  logic                   NET_TX_tready,
    output logic [31:0]            stat_frames
);
    localparam int KB = DATA_W / 8;
    localparam int S  = KB - HDR_BYTES;
    localparam int NW = $clog2(KB + 1) + 1;
    localparam logic [NW-1:0] H_N  = NW'(HDR_BYTES);
    localparam logic [NW-1:0] S_N  = NW'(S);
    localparam logic [NW-1:0] KB_N = NW'(KB);
`ifdef NET_SEND_MIN_FRAME_PAD_EN
    localparam logic [NW-1:0] MIN_N = NW'(60);
`endif

    typedef enum logic [1:0] {IDLE, FIRST, BODY, TAIL} state_t;

    state_t                 state;
    logic [HDR_BYTES*8-1:0] carry;
    logic [NW-1:0]          tail_cnt;
    logic                   active;

    logic                   slot_free;
    logic                   hs_hdr;
    logic                   hs_pay;
    logic [NW-1:0]          pay_cnt;
    logic                   fits;

    logic                   ld;
    logic                   ld_last;
    logic [DATA_W-1:0]      ld_word;
    logic [NW-1:0]          ld_dcnt;
    logic [NW-1:0]          ld_kcnt;

    function automatic logic [KB-1:0] low_ones(input logic [NW-1:0] c);
        logic [KB-1:0] m;
        for (int i = 0; i < KB; i++) m[i] = (NW'(i) < c);
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] byte_mask(input logic [KB-1:0] k);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < KB; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    // Keep count of a single-word frame; padding only ever widens keep, data stays masked to real bytes.
    function automatic logic [NW-1:0] frame_keep(input logic [NW-1:0] c);
`ifdef NET_SEND_MIN_FRAME_PAD_EN
        return (c < MIN_N) ? MIN_N : c;
`else
        return c;
`endif
    endfunction

    // Ready is held low for the first cycle after reset so every output reads 0 then.
    assign slot_free  = !NET_TX_tvalid || NET_TX_tready;
    assign hdr_tready = active && (state == IDLE) && slot_free;
    assign pay_tready = active && ((state == FIRST) || (state == BODY)) && slot_free;
    assign hs_hdr     = hdr_tvalid && hdr_tready;
    assign hs_pay     = pay_tvalid && pay_tready;

    always_comb begin
        pay_cnt = '0;
        for (int i = 0; i < KB; i++) begin
            if (pay_tkeep[i]) pay_cnt = pay_cnt + NW'(1);
        end
        if (!pay_tlast) pay_cnt = KB_N;
    end

    assign fits = pay_tlast && (pay_cnt <= S_N);

    always_comb begin
        ld      = 1'b0;
        ld_last = 1'b0;
        ld_word = '0;
        ld_dcnt = '0;
        ld_kcnt = '0;
        case (state)
            IDLE: begin
                if (hs_hdr && hdr_tuser) begin
                    ld      = 1'b1;
                    ld_last = 1'b1;
                    ld_word = {{(S*8){1'b0}}, hdr_tdata};
                    ld_dcnt = H_N;
                    ld_kcnt = frame_keep(H_N);
                end
            end
            FIRST, BODY: begin
                if (hs_pay) begin
                    ld      = 1'b1;
                    ld_word = {pay_tdata[S*8-1:0], carry};
                    if (fits) begin
                        ld_last = 1'b1;
                        ld_dcnt = H_N + pay_cnt;
                        ld_kcnt = (state == FIRST) ? frame_keep(H_N + pay_cnt) : (H_N + pay_cnt);
                    end else begin
                        ld_dcnt = KB_N;
                        ld_kcnt = KB_N;
                    end
                end
            end
            TAIL: begin
                if (slot_free) begin
                    ld      = 1'b1;
                    ld_last = 1'b1;
                    ld_word = {{(S*8){1'b0}}, carry};
                    ld_dcnt = tail_cnt;
                    ld_kcnt = tail_cnt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            carry         <= '0;
            tail_cnt      <= '0;
            active        <= 1'b0;
            NET_TX_tvalid <= 1'b0;
            NET_TX_tdata  <= '0;
            NET_TX_tkeep  <= '0;
            NET_TX_tlast  <= 1'b0;
            stat_frames   <= '0;
        end else begin
            active <= 1'b1;
            if (NET_TX_tvalid && NET_TX_tready && NET_TX_tlast) stat_frames <= stat_frames + 32'd1;

            if (ld) begin
                NET_TX_tvalid <= 1'b1;
                NET_TX_tdata  <= ld_word & byte_mask(low_ones(ld_dcnt));
                NET_TX_tkeep  <= low_ones(ld_kcnt);
                NET_TX_tlast  <= ld_last;
            end else if (slot_free) begin
                NET_TX_tvalid <= 1'b0;
            end

            // The header seeds the carry, so FIRST and BODY share one datapath.
            case (state)
                IDLE: begin
                    if (hs_hdr && !hdr_tuser) begin
                        carry <= hdr_tdata;
                        state <= FIRST;
                    end
                end
                FIRST, BODY: begin
                    if (hs_pay) begin
                        carry <= pay_tdata[DATA_W-1:S*8];
                        if (fits) begin
                            state <= IDLE;
                        end else if (pay_tlast) begin
                            tail_cnt <= pay_cnt - S_N;
                            state    <= TAIL;
                        end else begin
                            state <= BODY;
                        end
                    end
                end
                TAIL: begin
                    if (slot_free) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_net_send_frame_tx.sv
// tb/tb_net_send_frame_tx.sv - directed and backpressure checks of net_send_frame_tx against a byte-stream model
module tb_net_send_frame_tx;
    localparam int H  = 54;
    localparam int DW = 512;
    localparam int KB = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [H*8-1:0]  hdr_tdata;
    logic            hdr_tuser;
    logic            hdr_tvalid;
    logic            hdr_tready;
    logic [DW-1:0]   pay_tdata;
    logic [KB-1:0]   pay_tkeep;
    logic            pay_tlast;
    logic            pay_tvalid;
    logic            pay_tready;
    logic [DW-1:0]   NET_TX_tdata;
    logic [KB-1:0]   NET_TX_tkeep;
    logic            NET_TX_tlast;
    logic            NET_TX_tvalid;
    logic            NET_TX_tready;
    logic [31:0]     stat_frames;

    always #5 clk = ~clk;

    net_send_frame_tx #(.HDR_BYTES(H), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .hdr_tdata(hdr_tdata), .hdr_tuser(hdr_tuser), .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready),
        .pay_tdata(pay_tdata), .pay_tkeep(pay_tkeep), .pay_tlast(pay_tlast),
        .pay_tvalid(pay_tvalid), .pay_tready(pay_tready),
        .NET_TX_tdata(NET_TX_tdata), .NET_TX_tkeep(NET_TX_tkeep), .NET_TX_tlast(NET_TX_tlast),
        .NET_TX_tvalid(NET_TX_tvalid), .NET_TX_tready(NET_TX_tready),
        .stat_frames(stat_frames)
    );

    typedef struct packed { logic u; logic [H*8-1:0] d; } hdr_t;
    typedef struct packed { logic l; logic [KB-1:0] k; logic [DW-1:0] d; } word_t;

    hdr_t  hq[$];
    word_t pq[$];
    word_t eq[$];
    word_t cq[$];
    word_t rq[$];

    int total = 0;
    int bad = 0;
    int exp_frames = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Header byte i = hs+i, payload byte j = ps+j; bytes beyond keep on the last payload word are junk.
    task automatic gen_frame(input int len, input logic u, input logic [7:0] hs, input logic [7:0] ps);
        logic [7:0] fb[$];
        hdr_t  h;
        word_t w;
        int npw, nw, tb;
        h.u = u;
        h.d = '0;
        for (int i = 0; i < H; i++) begin
            h.d[8*i +: 8] = hs + 8'(i);
            fb.push_back(hs + 8'(i));
        end
        hq.push_back(h);
        if (!u) begin
            npw = (len == 0) ? 1 : (len + KB - 1) / KB;
            for (int wi = 0; wi < npw; wi++) begin
                w = '0;
                w.l = (wi == npw - 1);
                for (int b = 0; b < KB; b++) begin
                    if (wi * KB + b < len) begin
                        w.d[8*b +: 8] = ps + 8'(wi * KB + b);
                        w.k[b] = 1'b1;
                    end else begin
                        w.d[8*b +: 8] = 8'hEE;
                    end
                end
                pq.push_back(w);
            end
            for (int j = 0; j < len; j++) fb.push_back(ps + 8'(j));
        end
`ifdef NET_SEND_MIN_FRAME_PAD_EN
        while (fb.size() < 60) fb.push_back(8'h00);
`endif
        tb = fb.size();
        nw = (tb + KB - 1) / KB;
        for (int wi = 0; wi < nw; wi++) begin
            w = '0;
            w.l = (wi == nw - 1);
            for (int b = 0; b < KB; b++) begin
                if (wi * KB + b < tb) begin
                    w.d[8*b +: 8] = fb[wi * KB + b];
                    w.k[b] = 1'b1;
                end
            end
            eq.push_back(w);
        end
        exp_frames++;
    endtask

    task automatic run(input logic bp, input int budget);
        int cyc;
        logic stalled;
        logic [DW-1:0] hd;
        logic [KB:0] hkl;
        cyc = 0;
        stalled = 1'b0;
        hd = '0;
        hkl = '0;
        cq.delete();
        while ((eq.size() != 0 || hq.size() != 0 || pq.size() != 0) && cyc < budget) begin
            @(negedge clk);
            NET_TX_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            hdr_tvalid = (hq.size() != 0);
            if (hdr_tvalid) {hdr_tuser, hdr_tdata} = hq[0];
            pay_tvalid = (pq.size() != 0);
            if (pay_tvalid) {pay_tlast, pay_tkeep, pay_tdata} = pq[0];
            #1;
            if (stalled) begin
                check("stall_data", NET_TX_tdata, hd);
                check("stall_ctrl", DW'({NET_TX_tvalid, NET_TX_tlast, NET_TX_tkeep}), DW'({1'b1, hkl}));
            end
            if (NET_TX_tvalid && NET_TX_tready) begin
                if (eq.size() == 0) begin
                    check("tx_extra_word", DW'(NET_TX_tvalid), DW'(0));
                end else begin
                    check("tx_data", NET_TX_tdata, eq[0].d);
                    check("tx_keep_last", DW'({NET_TX_tlast, NET_TX_tkeep}), DW'({eq[0].l, eq[0].k}));
                    cq.push_back({NET_TX_tlast, NET_TX_tkeep, NET_TX_tdata});
                    void'(eq.pop_front());
                end
            end
            stalled = NET_TX_tvalid && !NET_TX_tready;
            hd = NET_TX_tdata;
            hkl = {NET_TX_tlast, NET_TX_tkeep};
            if (hdr_tvalid && hdr_tready) void'(hq.pop_front());
            if (pay_tvalid && pay_tready) void'(pq.pop_front());
            cyc++;
        end
        total++;
        assert (cyc < budget) else begin
            bad++;
            $error("FAIL run_timeout observed=%0d expected_below=%0d", cyc, budget);
        end
        @(negedge clk);
        hdr_tvalid = 1'b0;
        pay_tvalid = 1'b0;
        NET_TX_tready = 1'b1;
        #1;
        check("stat_frames", DW'(stat_frames), DW'(exp_frames));
    endtask

    int lens[100];
    logic hu[100];

    initial begin
        rst = 1'b1;
        hdr_tdata = '0; hdr_tuser = 1'b0; hdr_tvalid = 1'b0;
        pay_tdata = '0; pay_tkeep = '0; pay_tlast = 1'b0; pay_tvalid = 1'b0;
        NET_TX_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", DW'({hdr_tready, pay_tready, NET_TX_tvalid, NET_TX_tlast, NET_TX_tkeep}), DW'(0));
        check("reset_data", NET_TX_tdata, '0);
        check("reset_stat", DW'(stat_frames), DW'(0));
        rst = 1'b0;

        // Header-only frame
        gen_frame(0, 1'b1, 8'h80, 8'h40);
        run(1'b0, 200);
        check("hdr_only_count", DW'(cq.size()), DW'(1));
`ifdef NET_SEND_MIN_FRAME_PAD_EN
        check("hdr_only_keep", DW'(cq[0].k), DW'(64'h0FFF_FFFF_FFFF_FFFF));
`else
        check("hdr_only_keep", DW'(cq[0].k), DW'(64'h003F_FFFF_FFFF_FFFF));
`endif
        check("hdr_only_last", DW'(cq[0].l), DW'(1));
        check("hdr_only_b53", DW'(cq[0].d[53*8 +: 8]), DW'(8'hB5));
        check("hdr_only_pad0", DW'(cq[0].d[59*8+7 : 54*8]), DW'(0));

        // 10-byte payload fills the first word exactly
        gen_frame(10, 1'b0, 8'h80, 8'h40);
        run(1'b0, 200);
        check("p10_count", DW'(cq.size()), DW'(1));
        check("p10_keep", DW'(cq[0].k), DW'(64'hFFFF_FFFF_FFFF_FFFF));
        check("p10_last", DW'(cq[0].l), DW'(1));
        check("p10_b54", DW'(cq[0].d[54*8 +: 8]), DW'(8'h40));
        check("p10_b63", DW'(cq[0].d[63*8 +: 8]), DW'(8'h49));

        // 11-byte payload spills one byte into a tail word
        gen_frame(11, 1'b0, 8'h80, 8'h40);
        run(1'b0, 200);
        check("p11_count", DW'(cq.size()), DW'(2));
        check("p11_w0", DW'({cq[0].l, cq[0].k}), DW'({1'b0, 64'hFFFF_FFFF_FFFF_FFFF}));
        check("p11_w1_ctrl", DW'({cq[1].l, cq[1].k}), DW'({1'b1, 64'h1}));
        check("p11_w1_data", cq[1].d, DW'(8'h4A));

        // Two full payload words become three output words
        gen_frame(128, 1'b0, 8'h80, 8'h40);
        run(1'b0, 200);
        check("p128_count", DW'(cq.size()), DW'(3));
        check("p128_k0", DW'(cq[0].k), DW'(64'hFFFF_FFFF_FFFF_FFFF));
        check("p128_k1", DW'(cq[1].k), DW'(64'hFFFF_FFFF_FFFF_FFFF));
        check("p128_k2", DW'({cq[2].l, cq[2].k}), DW'({1'b1, 64'h003F_FFFF_FFFF_FFFF}));
        check("p128_w1b0", DW'(cq[1].d[7:0]), DW'(8'h4A));
        check("p128_w2b53", DW'(cq[2].d[53*8 +: 8]), DW'(8'hBF));

        // Empty last payload word and an exact one-word payload
        gen_frame(0, 1'b0, 8'h11, 8'h22);
        gen_frame(64, 1'b0, 8'h33, 8'h44);
        run(1'b0, 200);

        // Same 100 frames without and then with random output backpressure
        for (int f = 0; f < 100; f++) begin
            lens[f] = $urandom_range(0, 1500);
            hu[f] = ($urandom_range(0, 9) == 0);
        end
        for (int f = 0; f < 100; f++) gen_frame(lens[f], hu[f], 8'(f), 8'(3 * f + 7));
        run(1'b0, 20000);
        rq = cq;
        for (int f = 0; f < 100; f++) gen_frame(lens[f], hu[f], 8'(f), 8'(3 * f + 7));
        run(1'b1, 20000);
        check("bp_word_count", DW'(cq.size()), DW'(rq.size()));
        for (int i = 0; i < rq.size() && i < cq.size(); i++) begin
            check("bp_vs_free_data", cq[i].d, rq[i].d);
            check("bp_vs_free_ctrl", DW'({cq[i].l, cq[i].k}), DW'({rq[i].l, rq[i].k}));
        end

        // Reset in the middle of a 3-word frame
        @(negedge clk);
        hdr_tvalid = 1'b1; hdr_tuser = 1'b0; hdr_tdata = '1;
        @(negedge clk);
        hdr_tvalid = 1'b0;
        pay_tvalid = 1'b1; pay_tlast = 1'b0; pay_tkeep = '1; pay_tdata = '1;
        @(negedge clk);
        pay_tvalid = 1'b0;
        #1;
        check("body_valid", DW'({NET_TX_tvalid, hdr_tready, pay_tready}), DW'(3'b101));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ctrl", DW'({hdr_tready, pay_tready, NET_TX_tvalid, NET_TX_tlast, NET_TX_tkeep}), DW'(0));
        check("post_rst_data", NET_TX_tdata, '0);
        check("post_rst_stat", DW'(stat_frames), DW'(0));
        exp_frames = 0;
        gen_frame(10, 1'b0, 8'h80, 8'h40);
        run(1'b0, 200);
        check("after_rst_count", DW'(cq.size()), DW'(1));
        check("after_rst_ctrl", DW'({cq[0].l, cq[0].k}), DW'({1'b1, 64'hFFFF_FFFF_FFFF_FFFF}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
